// File: rtl/hamming_pkg.sv
// Shared Hamming helpers for the stream encoder and the future decoder.
// Build option: define HAMMING_SECDED_EN to append an overall even-parity bit (SEC-DED).
package hamming_pkg;

  localparam int MAX_DATA_W = 57;
  localparam int MAX_CW_W   = 64;

`ifdef HAMMING_SECDED_EN
  localparam int SECDED_BITS = 1;
`else
  localparam int SECDED_BITS = 0;
`endif

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_e;

  // Smallest p with 2**p >= data_w + p + 1.
  function automatic int par_w(input int data_w);
    int p;
    p = 0;
    for (int i = 1; i < 8; i++) begin
      if (p == 0 && (1 << i) >= data_w + i + 1) begin
        p = i;
      end
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position i (1-based) lives in bit i-1; bits above the codeword stay zero.
  function automatic logic [MAX_CW_W-1:0] hamming_encode(
    input logic [MAX_DATA_W-1:0] data,
    input int                    data_w,
    input bit                    secded
  );
    logic [MAX_CW_W-1:0] cw;
    logic [5:0]          di;
    logic                par;
    int                  n;
    cw = '0;
    di = '0;
    n  = data_w + par_w(data_w);
    for (int pos = 1; pos < MAX_CW_W; pos++) begin
      if (pos <= n && !is_pow2(pos)) begin
        cw[6'(pos - 1)] = data[di];
        di = di + 6'd1;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int pos = 1; pos < MAX_CW_W; pos++) begin
        if (pos <= n && !is_pow2(pos) && (pos & (1 << k)) != 0) begin
          par = par ^ cw[6'(pos - 1)];
        end
      end
      if ((1 << k) <= n) begin
        cw[6'((1 << k) - 1)] = par;
      end
    end
    if (secded && n < MAX_CW_W) begin
      cw[6'(n)] = ^cw;
    end
    return cw;
  endfunction

endpackage

// File: rtl/hamming_skid_buf.sv
// Two-entry valid/ready skid buffer: output register plus one skid register.
// in_ready and out_valid are both registered so neither side sees a combinational path.
module hamming_skid_buf
  import hamming_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             pop;

  always_comb begin
    accept      = in_valid & in_ready_q;
    pop         = out_valid_q & out_ready;
    state_d     = state_q;
    or_d        = or_q;
    sr_d        = sr_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          or_d    = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && pop) begin
          or_d = in_data;
        end else if (accept) begin
          sr_d    = in_data;
          state_d = SKID_TWO;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        // The skid word always drains first so ordering is preserved.
        if (pop) begin
          or_d = sr_q;
          if (accept) begin
            sr_d = in_data;
          end else begin
            state_d = SKID_ONE;
          end
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    out_valid_d = (state_d != SKID_EMPTY);
    in_ready_d  = (state_d != SKID_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SKID_EMPTY;
      or_q        <= '0;
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      or_q        <= or_d;
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = or_q;

endmodule

// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming encoder: combinational encode feeding a 2-entry skid buffer, plus a pop counter.
// Build option: HAMMING_SECDED_EN (via hamming_pkg) widens out_cw by one overall-parity bit.
module hamming_stream_encoder
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = par_w(DATA_W),
  localparam int CW_W   = DATA_W + PAR_W + SECDED_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_cw,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  word_cnt
);

  logic [CW_W-1:0]  cw_enc;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             pop;

  always_comb begin
    cw_enc = CW_W'(hamming_encode(MAX_DATA_W'(in_data), DATA_W, SECDED_BITS != 0));
  end

  hamming_skid_buf #(
    .WIDTH(CW_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (cw_enc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_cw)
  );

  // Clear wins over a simultaneous pop.
  always_comb begin
    pop        = out_valid & out_ready;
    word_cnt_d = word_cnt_q;
    if (cnt_clr) begin
      word_cnt_d = '0;
    end else if (pop) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Bench for hamming_stream_encoder: DATA_W=4 and DATA_W=26 instances, table vectors plus a scoreboard.
// Honours HAMMING_SECDED_EN to pick the matching codeword widths and expected constants.
module tb_hamming_stream_encoder;

`ifdef HAMMING_SECDED_EN
  localparam int TB_SEC = 1;
`else
  localparam int TB_SEC = 0;
`endif
  localparam int N4   = 7;
  localparam int N26  = 31;
  localparam int CW4  = N4 + TB_SEC;
  localparam int CW26 = N26 + TB_SEC;

  logic clk;
  logic rst_n;

  logic           in_valid4, in_ready4, out_valid4, out_ready4, cnt_clr4;
  logic [3:0]     in_data4;
  logic [CW4-1:0] out_cw4;
  logic [15:0]    word_cnt4;

  logic            in_valid26, in_ready26, out_valid26, out_ready26, cnt_clr26;
  logic [25:0]     in_data26;
  logic [CW26-1:0] out_cw26;
  logic [3:0]      word_cnt26;

  int checks = 0;
  int errors = 0;
  logic [63:0] q4[$];
  logic [63:0] q26[$];
  logic [63:0] exp4, exp26, got26;

  typedef struct {
    logic [3:0] data;
    logic [6:0] exp_plain;
    logic [7:0] exp_sec;
  } vec_t;
  vec_t vecs[5];

  hamming_stream_encoder #(.DATA_W(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_cw(out_cw4), .cnt_clr(cnt_clr4), .word_cnt(word_cnt4)
  );

  hamming_stream_encoder #(.DATA_W(26), .CNT_W(4)) dut26 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid26), .in_ready(in_ready26),
    .in_data(in_data26), .out_valid(out_valid26), .out_ready(out_ready26),
    .out_cw(out_cw26), .cnt_clr(cnt_clr26), .word_cnt(word_cnt26)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: place data, then set parity bits to the syndrome of the data positions.
  function automatic logic [63:0] ref_encode(input logic [63:0] data, input int dw, input int sec);
    logic [63:0] cw;
    logic [7:0]  syn;
    int p, n, di;
    p = 0;
    while ((1 << p) < dw + p + 1) p++;
    n = dw + p;
    cw = '0;
    syn = '0;
    di = 0;
    for (int pos = 1; pos <= n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = data[di];
        if (data[di]) syn = syn ^ 8'(pos);
        di++;
      end
    end
    for (int k = 0; k < p; k++) cw[(1 << k) - 1] = syn[k];
    if (sec != 0) cw[n] = ^cw;
    return cw;
  endfunction

  function automatic logic [7:0] ref_syndrome(input logic [63:0] cw, input int n);
    logic [7:0] s;
    s = '0;
    for (int pos = 1; pos <= n; pos++) begin
      if (cw[pos-1]) s = s ^ 8'(pos);
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d);
    in_valid4 = 1'b1;
    in_data4  = d;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  // Scoreboard: push expected codewords on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      q26.delete();
    end else begin
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) begin
          checkOutput("sb4_unexpected", 64'(out_cw4), 64'hDEAD);
        end else begin
          exp4 = q4.pop_front();
          checkOutput("sb4_cw", 64'(out_cw4), exp4);
        end
      end
      if (in_valid4 && in_ready4) q4.push_back(ref_encode(64'(in_data4), 4, TB_SEC));
      if (out_valid26 && out_ready26) begin
        got26 = 64'(out_cw26);
        checkOutput("syn26", {55'd0, ref_syndrome(got26, N26), (TB_SEC != 0) ? ^got26 : 1'b0}, 64'd0);
        if (q26.size() == 0) begin
          checkOutput("sb26_unexpected", got26, 64'hDEAD);
        end else begin
          exp26 = q26.pop_front();
          checkOutput("sb26_cw", got26, exp26);
        end
      end
      if (in_valid26 && in_ready26) q26.push_back(ref_encode(64'(in_data26), 26, TB_SEC));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accepted, pops, gaps, stalls;
    vecs[0] = '{4'b1011, 7'h55, 8'h55};
    vecs[1] = '{4'hF,    7'h7F, 8'hFF};
    vecs[2] = '{4'h0,    7'h00, 8'h00};
    vecs[3] = '{4'b0001, 7'h07, 8'h87};
    vecs[4] = '{4'b1000, 7'h4B, 8'h4B};

    rst_n = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1; cnt_clr4 = 1'b0;
    in_valid26 = 1'b0; in_data26 = '0; out_ready26 = 1'b1; cnt_clr26 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid4), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready4), 64'd1);
    checkOutput("rst_word_cnt", 64'(word_cnt4), 64'd0);
    checkOutput("rst_out_cw", 64'(out_cw4), 64'd0);
    checkOutput("rst_out_valid26", 64'(out_valid26), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].data);
      checkOutput("vec_valid", 64'(out_valid4), 64'd1);
      checkOutput("vec_cw", 64'(out_cw4), (TB_SEC != 0) ? 64'(vecs[i].exp_sec) : 64'(vecs[i].exp_plain));
      @(posedge clk); #1;
    end
    checkOutput("vec_word_cnt", 64'(word_cnt4), 64'd5);

    // Back-pressure: only two words fit while the sink stalls.
    out_ready4 = 1'b0;
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      if (in_ready4) accepted++;
      in_valid4 = 1'b1;
      in_data4  = 4'(i + 3);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    checkOutput("bp_accepted", 64'(accepted), 64'd2);
    checkOutput("bp_in_ready", 64'(in_ready4), 64'd0);
    checkOutput("bp_cw_held", 64'(out_cw4), ref_encode(64'd3, 4, TB_SEC));
    out_ready4 = 1'b1;
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid4) pops++;
      @(posedge clk); #1;
    end
    checkOutput("bp_drained", 64'(pops), 64'd2);
    checkOutput("bp_queue_empty", 64'(q4.size()), 64'd0);

    // Streaming 100 words back to back.
    cnt_clr4 = 1'b1;
    @(posedge clk); #1;
    cnt_clr4 = 1'b0;
    checkOutput("clr_word_cnt", 64'(word_cnt4), 64'd0);
    gaps = 0;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0 && !out_valid4) gaps++;
      if (!in_ready4) stalls++;
      in_valid4 = 1'b1;
      in_data4  = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    checkOutput("stream_gaps", 64'(gaps), 64'd0);
    checkOutput("stream_stalls", 64'(stalls), 64'd0);
    checkOutput("stream_word_cnt", 64'(word_cnt4), 64'd100);
    checkOutput("stream_idle", 64'(out_valid4), 64'd0);

    // Reset with both registers full drops everything.
    out_ready4 = 1'b0;
    applyStimulus(4'h9);
    applyStimulus(4'h6);
    checkOutput("full_out_valid", 64'(out_valid4), 64'd1);
    checkOutput("full_in_ready", 64'(in_ready4), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("mid_rst_out_valid", 64'(out_valid4), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready4), 64'd1);
    checkOutput("mid_rst_word_cnt", 64'(word_cnt4), 64'd0);
    out_ready4 = 1'b1;

    // Clear beats a simultaneous pop.
    applyStimulus(4'h2);
    @(posedge clk); #1;
    checkOutput("pre_clr_cnt", 64'(word_cnt4), 64'd1);
    applyStimulus(4'h5);
    cnt_clr4 = 1'b1;
    @(posedge clk); #1;
    cnt_clr4 = 1'b0;
    checkOutput("clr_with_pop", 64'(word_cnt4), 64'd0);

    // DATA_W=26: random traffic and stalls against the reference model.
    for (int i = 0; i < 60; i++) begin
      in_valid26  = 1'($urandom_range(0, 1));
      in_data26   = 26'($urandom);
      out_ready26 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid26 = 1'b0;
    out_ready26 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rand26_drained", 64'(q26.size()), 64'd0);

    // CNT_W=4 wraps: 17 pops leave 1.
    cnt_clr26 = 1'b1;
    @(posedge clk); #1;
    cnt_clr26 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid26 = 1'b1;
      in_data26  = 26'($urandom);
      @(posedge clk); #1;
    end
    in_valid26 = 1'b0;
    @(posedge clk); #1;
    checkOutput("wrap26_word_cnt", 64'(word_cnt26), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
